board_judge: RTL and testbench

Downstream consumer of the game controller. Holds the 9-cell tic-tac-toe board and applies each controller write (addr, cellState). After every accepted move it scans the 8 winning lines, one per cycle. It then produces gameIsDone and winner, which feed back to the controller; a combinational read port serves the display.

---
 rtl/ttt_pkg.sv | 47 ++++
 rtl/board_judge_if.sv | 31 +++
 rtl/board_judge.sv | 97 +++++++++
 tb/tb_board_judge.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared tic-tac-toe types, winning-line table and win test
//
// Purpose: common definitions used by the game controller and the board judge.
//   cellStateType  : EMPTY / O / X encoding of one board cell
//   judgeStateType : IDLE / SCAN / DONE states of the judge
//   LINES          : cell indices of the 8 winning lines (rows, columns, diagonals)
//   lineWins()     : true when three cells hold the same non-empty mark
package ttt_pkg;

   localparam int NCELLS = 9;
   localparam int ADDRW  = 4;
   localparam int NLINES = 8;

   localparam logic [ADDRW-1:0] CELLLIMIT = ADDRW'(NCELLS);
   localparam logic [3:0]       FULLCOUNT = 4'(NCELLS);
   localparam logic [2:0]       LASTLINE  = 3'(NLINES - 1);

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      X     = 2'b10,
      O     = 2'b11
   } cellStateType;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SCAN = 2'b01,
      DONE = 2'b10
   } judgeStateType;

   // Scan order matters: the first matching entry decides the winner.
   localparam logic [3:0] LINES [0:NLINES-1][0:2] = '{
      '{4'd0, 4'd1, 4'd2},
      '{4'd3, 4'd4, 4'd5},
      '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6},
      '{4'd1, 4'd4, 4'd7},
      '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8},
      '{4'd2, 4'd4, 4'd6}
   };

   function automatic logic lineWins(input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] c);
      return (a != EMPTY) && (a == b) && (b == c);
   endfunction

endpackage

// File: rtl/board_judge_if.sv
// rtl/board_judge_if.sv - controller/display bus of the board judge
//
// Purpose: groups the controller write port, the result outputs and the
// display read port.
//   master (controller/display): drives clearBoard, wrEn, addr, cellState, rdAddr
//   slave  (board_judge)       : drives rdState, busy, wrReject, gameIsDone, winner
interface board_judge_if;
   import ttt_pkg::*;

   logic             clearBoard;
   logic             wrEn;
   logic [ADDRW-1:0] addr;
   logic [1:0]       cellState;
   logic [ADDRW-1:0] rdAddr;
   logic [1:0]       rdState;
   logic             busy;
   logic             wrReject;
   logic             gameIsDone;
   logic [1:0]       winner;

   modport master (
      output clearBoard, wrEn, addr, cellState, rdAddr,
      input  rdState, busy, wrReject, gameIsDone, winner
   );

   modport slave (
      input  clearBoard, wrEn, addr, cellState, rdAddr,
      output rdState, busy, wrReject, gameIsDone, winner
   );

endinterface

// File: rtl/board_judge.sv
// rtl/board_judge.sv - tic-tac-toe board store with sequential win/draw scan
//
// Purpose: holds the 9 cells, accepts controller writes, then scans one
// winning line per cycle and reports a win or draw.
// Ports:
//   ph1   : clock, all state changes on its rising edge
//   reset : asynchronous active-low reset
//   bus   : board_judge_if.slave (write port, results, display read port)
module board_judge
   import ttt_pkg::*;
(
   input logic          ph1,
   input logic          reset,
   board_judge_if.slave bus
);

   logic [1:0]    board [0:NCELLS-1];
   logic [3:0]    moveCount;
   logic [2:0]    lineIdx;
   logic [1:0]    winnerReg;
   logic          wrRejectReg;
   judgeStateType state, nextState;

   logic          accept;
   logic          lineHit;
   logic [1:0]    cellA, cellB, cellC;

   assign cellA = board[LINES[lineIdx][0]];
   assign cellB = board[LINES[lineIdx][1]];
   assign cellC = board[LINES[lineIdx][2]];

   assign lineHit = (state == SCAN) && lineWins(cellA, cellB, cellC);

   // Address is range-checked before the occupancy lookup is meaningful.
   assign accept = bus.wrEn && (state == IDLE) && (bus.addr < CELLLIMIT)
                && (board[bus.addr] == EMPTY)
                && ((bus.cellState == X) || (bus.cellState == O));

   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: if (accept) nextState = SCAN;
         SCAN: begin
            if (lineHit) begin
               nextState = DONE;
            end else if (lineIdx == LASTLINE) begin
               nextState = (moveCount == FULLCOUNT) ? DONE : IDLE;
            end
         end
         DONE:    nextState = DONE;
         default: nextState = IDLE;
      endcase
      if (bus.clearBoard) nextState = IDLE;
   end

   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NCELLS; i++) board[i] <= EMPTY;
         moveCount   <= '0;
         lineIdx     <= '0;
         winnerReg   <= EMPTY;
         wrRejectReg <= 1'b0;
      end else if (bus.clearBoard) begin
         // A write coinciding with clear is silently dropped.
         for (int i = 0; i < NCELLS; i++) board[i] <= EMPTY;
         moveCount   <= '0;
         lineIdx     <= '0;
         winnerReg   <= EMPTY;
         wrRejectReg <= 1'b0;
      end else begin
         wrRejectReg <= bus.wrEn && !accept;
         if (accept) begin
            board[bus.addr] <= bus.cellState;
            if (moveCount != FULLCOUNT) moveCount <= moveCount + 4'd1;
            lineIdx <= '0;
         end else if (state == SCAN) begin
            if (lineHit) winnerReg <= cellA;
            if (lineIdx != LASTLINE) lineIdx <= lineIdx + 3'd1;
         end
      end
   end

   assign bus.busy       = (state == SCAN);
   assign bus.gameIsDone = (state == DONE);
   assign bus.winner     = winnerReg;
   assign bus.wrReject   = wrRejectReg;
   assign bus.rdState    = (bus.rdAddr < CELLLIMIT) ? board[bus.rdAddr] : EMPTY;

endmodule

// File: tb/tb_board_judge.sv
// tb/tb_board_judge.sv - self-checking bench for board_judge
module tb_board_judge;

   logic ph1 = 1'b0;
   logic reset;

   board_judge_if bus();

   board_judge dut (
      .ph1  (ph1),
      .reset(reset),
      .bus  (bus)
   );

   always #5 ph1 = ~ph1;

   int checks = 0;
   int errors = 0;

   // Independent copy of the winning lines, in scan priority order.
   int tbLines [0:7][0:2] = '{
      '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
      '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
      '{0, 4, 8}, '{2, 4, 6}
   };

   // Model: phase 0 idle, 1 scanning, 2 done. A scan's outcome is computed
   // the moment the move is accepted and released after the scan latency.
   int mBoard [0:8];
   int mMoves;
   int mPhase;
   int mScanLeft;
   int mPendWinner;
   bit mPendDone;
   int mWinner;
   bit mReject;
   bit modelOn = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 9; i++) mBoard[i] = 0;
      mMoves = 0; mPhase = 0; mScanLeft = 0;
      mPendWinner = 0; mPendDone = 1'b0; mWinner = 0; mReject = 1'b0;
   endtask

   task automatic modelEdge();
      bit acc;
      int a;
      int cs;
      int wl;
      if (!reset || bus.clearBoard) begin
         modelReset();
         return;
      end
      a   = int'(bus.addr);
      cs  = int'(bus.cellState);
      acc = 1'b0;
      if (bus.wrEn && mPhase == 0 && a < 9) begin
         if (mBoard[a] == 0 && (cs == 2 || cs == 3)) acc = 1'b1;
      end
      mReject = bus.wrEn && !acc;
      if (mPhase == 1) begin
         mScanLeft--;
         if (mScanLeft == 0) begin
            if (mPendDone) begin
               mPhase  = 2;
               mWinner = mPendWinner;
            end else begin
               mPhase = 0;
            end
         end
      end
      if (acc) begin
         mBoard[a] = cs;
         if (mMoves < 9) mMoves++;
         wl = -1;
         for (int k = 0; k < 8; k++) begin
            if (wl < 0 && mBoard[tbLines[k][0]] != 0
                && mBoard[tbLines[k][0]] == mBoard[tbLines[k][1]]
                && mBoard[tbLines[k][1]] == mBoard[tbLines[k][2]]) wl = k;
         end
         if (wl >= 0) begin
            mScanLeft   = wl + 1;
            mPendDone   = 1'b1;
            mPendWinner = mBoard[tbLines[wl][0]];
         end else begin
            mScanLeft   = 8;
            mPendDone   = (mMoves == 9);
            mPendWinner = 0;
         end
         mPhase = 1;
      end
   endtask

   always @(negedge ph1) begin
      if (modelOn) begin
         chk("cyc_busy",     int'(bus.busy),       int'(mPhase == 1));
         chk("cyc_done",     int'(bus.gameIsDone), int'(mPhase == 2));
         chk("cyc_winner",   int'(bus.winner),     mWinner);
         chk("cyc_wrReject", int'(bus.wrReject),   int'(mReject));
         chk("cyc_rdState",  int'(bus.rdState),
             (int'(bus.rdAddr) < 9) ? mBoard[int'(bus.rdAddr)] : 0);
      end
   end

   task automatic tick();
      @(posedge ph1);
      modelEdge();
      #1;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (bus.busy && n < 20) begin
         tick();
         n++;
      end
      chk("wait_idle", int'(bus.busy), 0);
   endtask

   task automatic issue(input int a, input int cs);
      bus.addr      = 4'(a);
      bus.cellState = 2'(cs);
      bus.wrEn      = 1'b1;
      tick();
      bus.wrEn      = 1'b0;
   endtask

   task automatic doWrite(input int a, input int cs);
      waitIdle();
      issue(a, cs);
   endtask

   task automatic clearGame();
      bus.clearBoard = 1'b1;
      tick();
      bus.clearBoard = 1'b0;
   endtask

   task automatic readCell(input int a, output int v);
      bus.rdAddr = 4'(a);
      #1;
      v = int'(bus.rdState);
   endtask

   task automatic scanToEnd(input string tag);
      for (int e = 0; e < 8; e++) begin
         chk({tag, "_busy"}, int'(bus.busy), 1);
         chk({tag, "_notdone"}, int'(bus.gameIsDone), 0);
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int v;
      reset          = 1'b0;
      bus.clearBoard = 1'b0;
      bus.wrEn       = 1'b0;
      bus.addr       = '0;
      bus.cellState  = '0;
      bus.rdAddr     = '0;
      modelReset();
      modelOn = 1'b1;
      tick();
      tick();
      reset = 1'b1;

      chk("rst_busy",     int'(bus.busy),       0);
      chk("rst_done",     int'(bus.gameIsDone), 0);
      chk("rst_winner",   int'(bus.winner),     0);
      chk("rst_wrReject", int'(bus.wrReject),   0);
      chk("rst_rdState",  int'(bus.rdState),    0);

      // Row 0 win by X, found on the first scanned line.
      doWrite(0, 2); doWrite(3, 3); doWrite(1, 2); doWrite(4, 3); doWrite(2, 2);
      chk("row_busyE0", int'(bus.busy), 1);
      chk("row_doneE0", int'(bus.gameIsDone), 0);
      tick();
      chk("row_doneE1", int'(bus.gameIsDone), 1);
      chk("row_winner", int'(bus.winner), 2);
      chk("row_busyE1", int'(bus.busy), 0);
      issue(5, 3);
      chk("done_reject", int'(bus.wrReject), 1);
      tick();
      chk("done_reject_end", int'(bus.wrReject), 0);
      readCell(5, v);
      chk("done_cell5", v, 0);
      clearGame();

      // Anti-diagonal win by O, found on the last scanned line.
      doWrite(2, 3); doWrite(0, 2); doWrite(4, 3); doWrite(1, 2); doWrite(6, 3);
      scanToEnd("diag");
      chk("diag_doneE8", int'(bus.gameIsDone), 1);
      chk("diag_winner", int'(bus.winner), 3);
      chk("diag_busyE8", int'(bus.busy), 0);

      // Asynchronous reset between edges while in DONE.
      bus.rdAddr = 4'd2;
      #2;
      reset = 1'b0;
      modelReset();
      #1;
      chk("arst_done",    int'(bus.gameIsDone), 0);
      chk("arst_winner",  int'(bus.winner),     0);
      chk("arst_busy",    int'(bus.busy),       0);
      chk("arst_rdState", int'(bus.rdState),    0);
      tick();
      reset = 1'b1;

      // Full board with no line: draw.
      doWrite(0, 2); doWrite(1, 3); doWrite(2, 2); doWrite(3, 2); doWrite(4, 3);
      doWrite(5, 3); doWrite(6, 3); doWrite(7, 2); doWrite(8, 2);
      scanToEnd("draw");
      chk("draw_done",   int'(bus.gameIsDone), 1);
      chk("draw_winner", int'(bus.winner),     0);
      clearGame();

      // Refusals: occupied cell, out-of-range address, bad mark, busy.
      doWrite(4, 2);
      waitIdle();
      issue(4, 3);
      chk("occ_reject", int'(bus.wrReject), 1);
      readCell(4, v);
      chk("occ_cell4", v, 2);
      tick();
      chk("occ_reject_end", int'(bus.wrReject), 0);
      issue(9, 2);
      chk("addr9_reject", int'(bus.wrReject), 1);
      tick();
      chk("addr9_reject_end", int'(bus.wrReject), 0);
      issue(0, 1);
      chk("mark01_reject", int'(bus.wrReject), 1);
      readCell(0, v);
      chk("mark01_cell0", v, 0);
      tick();
      chk("mark01_reject_end", int'(bus.wrReject), 0);
      issue(0, 2);
      chk("acc_noreject", int'(bus.wrReject), 0);
      chk("acc_busy", int'(bus.busy), 1);
      issue(1, 3);
      chk("busy_reject", int'(bus.wrReject), 1);
      readCell(1, v);
      chk("busy_cell1", v, 0);
      tick();
      chk("busy_reject_end", int'(bus.wrReject), 0);

      // Clear mid-scan together with a write.
      chk("pre_clear_busy", int'(bus.busy), 1);
      bus.clearBoard = 1'b1;
      bus.wrEn       = 1'b1;
      bus.addr       = 4'd5;
      bus.cellState  = 2'b10;
      tick();
      bus.clearBoard = 1'b0;
      bus.wrEn       = 1'b0;
      chk("clr_busy",     int'(bus.busy),       0);
      chk("clr_done",     int'(bus.gameIsDone), 0);
      chk("clr_wrReject", int'(bus.wrReject),   0);
      for (int i = 0; i < 9; i++) begin
         readCell(i, v);
         chk("clr_cell", v, 0);
         tick();
      end

      modelOn = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
